// File: rtl/tcm_pkg.sv
// Shared TCM definitions: loader states, port geometry and the
// byte-strobe type used by the Memory port and pipeline store logic.
package tcm_pkg;

    localparam int TCM_ADDR_WIDTH = 14;
    localparam int TCM_WORD_BYTES = 4;

    typedef logic [TCM_WORD_BYTES-1:0] wstrb_t;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        WRITE,
        DONE,
        ERROR
    } loader_state_t;

endpackage

// File: rtl/tcm_loader_if.sv
// Byte-stream and TCM write bus seen by the loader.
// master = loader side, slave = host/stream and memory side.
interface tcm_loader_if #(
    parameter int ADDR_WIDTH = 14
);
    import tcm_pkg::*;

    logic [7:0]            byte_i;
    logic                  byte_valid_i;
    logic                  byte_last_i;
    logic                  byte_ready_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [31:0]           mem_data_o;
    wstrb_t                mem_wr_o;

    modport master (
        input  byte_i,
        input  byte_valid_i,
        input  byte_last_i,
        output byte_ready_o,
        output mem_addr_o,
        output mem_data_o,
        output mem_wr_o
    );

    modport slave (
        output byte_i,
        output byte_valid_i,
        output byte_last_i,
        input  byte_ready_o,
        input  mem_addr_o,
        input  mem_data_o,
        input  mem_wr_o
    );

endinterface

// File: rtl/byte_packer.sv
// Packs little-endian bytes into a 32-bit word with a per-lane strobe.
// Unwritten lanes stay zero in both data and mask.
module byte_packer
    import tcm_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        clear_i,
    input  logic        push_i,
    input  logic [7:0]  byte_i,
    output logic        word_full_o,
    output wstrb_t      mask_o,
    output logic [31:0] word_o
);

    logic [1:0]  lane_q, lane_d;
    wstrb_t      mask_q, mask_d;
    logic [31:0] word_q, word_d;

    // Clear wins over push; a push lands the byte in the current lane.
    always_comb begin
        lane_d = lane_q;
        mask_d = mask_q;
        word_d = word_q;
        if (clear_i) begin
            lane_d = '0;
            mask_d = '0;
            word_d = '0;
        end else if (push_i) begin
            lane_d                      = lane_q + 2'd1;
            mask_d[lane_q]              = 1'b1;
            word_d[{lane_q, 3'b000} +: 8] = byte_i;
        end
    end

    // Lane, mask and data registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lane_q <= '0;
            mask_q <= '0;
            word_q <= '0;
        end else begin
            lane_q <= lane_d;
            mask_q <= mask_d;
            word_q <= word_d;
        end
    end

    assign word_full_o = push_i && (lane_q == 2'd3);
    assign mask_o      = mask_q;
    assign word_o      = word_q;

endmodule

// File: rtl/tcm_loader.sv
// Boot loader: streams an image into the TCM one word per WRITE
// cycle and holds the pipeline in reset until the image is complete.
module tcm_loader
    import tcm_pkg::*;
#(
    parameter int ADDR_WIDTH     = TCM_ADDR_WIDTH,
    parameter int BASE_WORD_ADDR = 0,
    parameter int MAX_WORDS      = 16384
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start_i,
    tcm_loader_if.master        bus,
    output logic                cpu_reset_o,
    output logic                done_o,
    output logic                error_o,
    output logic [ADDR_WIDTH:0] words_written_o
);

    localparam logic [ADDR_WIDTH-1:0] BASE_A = BASE_WORD_ADDR[ADDR_WIDTH-1:0];
    localparam logic [ADDR_WIDTH:0]   MAX_C  = MAX_WORDS[ADDR_WIDTH:0];

    loader_state_t         state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic                  last_q, last_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  crst_q, crst_d;

    logic        ready;
    logic        push;
    logic        clear;
    logic        full;
    wstrb_t      mask;
    logic [31:0] word;

    assign ready = (state_q == COLLECT) && (cnt_q != MAX_C);
    assign push  = ready && bus.byte_valid_i;

    byte_packer u_packer (
        .clock       (clock),
        .reset       (reset),
        .clear_i     (clear),
        .push_i      (push),
        .byte_i      (bus.byte_i),
        .word_full_o (full),
        .mask_o      (mask),
        .word_o      (word)
    );

    // Next-state logic: load sequencing, overflow and restart.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        done_d  = done_q;
        err_d   = err_q;
        crst_d  = crst_q;
        clear   = 1'b0;
        unique case (state_q)
            IDLE, DONE, ERROR: begin
                if (start_i) begin
                    state_d = COLLECT;
                    clear   = 1'b1;
                    addr_d  = BASE_A;
                    cnt_d   = '0;
                    last_d  = 1'b0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    crst_d  = 1'b1;
                end
            end
            COLLECT: begin
                if (cnt_q == MAX_C) begin
                    if (bus.byte_valid_i) begin
                        state_d = ERROR;
                        err_d   = 1'b1;
                    end
                end else if (push && (full || bus.byte_last_i)) begin
                    state_d = WRITE;
                    last_d  = bus.byte_last_i;
                end
            end
            WRITE: begin
                clear  = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                addr_d = addr_q + 1'b1;
                if (last_q) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    crst_d  = 1'b0;
                end else begin
                    state_d = COLLECT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, address, counter and status registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= BASE_A;
            cnt_q   <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            crst_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            done_q  <= done_d;
            err_q   <= err_d;
            crst_q  <= crst_d;
        end
    end

    assign bus.byte_ready_o = ready;
    assign bus.mem_addr_o   = addr_q;
    assign bus.mem_data_o   = word;
    assign bus.mem_wr_o     = (state_q == WRITE) ? mask : '0;
    assign cpu_reset_o      = crst_q;
    assign done_o           = done_q;
    assign error_o          = err_q;
    assign words_written_o  = cnt_q;

endmodule

// File: tb/tb_tcm_loader.sv
// Directed bench for tcm_loader: vector table of images plus
// overflow and reset-mid-load sequences.
module tb_tcm_loader;
    import tcm_pkg::*;

    typedef struct packed {
        logic [3:0]       n;
        logic             gap;
        logic [63:0]      bytes;
        logic [1:0]       nwr;
        logic [1:0][31:0] data;
        logic [1:0][3:0]  wr;
    } vec_t;

    typedef struct packed {
        logic [13:0] addr;
        logic [31:0] data;
        logic [3:0]  wr;
    } rec_t;

    logic       clock = 1'b0;
    logic       reset;
    logic       start_s;
    logic       sel;
    logic [7:0] byte_s;
    logic       valid_s;
    logic       last_s;

    logic        crst0, done0, err0, crst1, done1, err1;
    logic [14:0] ww0, ww1;

    logic        ready_m, crst_m, done_m, err_m;
    logic [14:0] ww_m;
    logic [13:0] addr_m;
    logic [31:0] data_m;
    logic [3:0]  wr_m;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   rdy_bad = 0;
    rec_t wq[$];
    vec_t vecs[6];

    always #5 clock = ~clock;

    tcm_loader_if #(.ADDR_WIDTH(14)) b0 ();
    tcm_loader_if #(.ADDR_WIDTH(14)) b1 ();

    assign b0.byte_i       = byte_s;
    assign b0.byte_valid_i = valid_s & ~sel;
    assign b0.byte_last_i  = last_s;
    assign b1.byte_i       = byte_s;
    assign b1.byte_valid_i = valid_s & sel;
    assign b1.byte_last_i  = last_s;

    tcm_loader #(.ADDR_WIDTH(14), .BASE_WORD_ADDR(0), .MAX_WORDS(16384)) dut (
        .clock           (clock),
        .reset           (reset),
        .start_i         (start_s & ~sel),
        .bus             (b0),
        .cpu_reset_o     (crst0),
        .done_o          (done0),
        .error_o         (err0),
        .words_written_o (ww0)
    );

    tcm_loader #(.ADDR_WIDTH(14), .BASE_WORD_ADDR(0), .MAX_WORDS(2)) dut_ovf (
        .clock           (clock),
        .reset           (reset),
        .start_i         (start_s & sel),
        .bus             (b1),
        .cpu_reset_o     (crst1),
        .done_o          (done1),
        .error_o         (err1),
        .words_written_o (ww1)
    );

    assign ready_m = sel ? b1.byte_ready_o : b0.byte_ready_o;
    assign addr_m  = sel ? b1.mem_addr_o   : b0.mem_addr_o;
    assign data_m  = sel ? b1.mem_data_o   : b0.mem_data_o;
    assign wr_m    = sel ? b1.mem_wr_o     : b0.mem_wr_o;
    assign crst_m  = sel ? crst1 : crst0;
    assign done_m  = sel ? done1 : done0;
    assign err_m   = sel ? err1  : err0;
    assign ww_m    = sel ? ww1   : ww0;

    // Record every write strobe cycle, away from the active edge.
    always @(negedge clock) begin
        if (wr_m != 4'b0000) begin
            wq.push_back('{addr: addr_m, data: data_m, wr: wr_m});
            if (ready_m) rdy_bad++;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start();
        start_s = 1'b1;
        tick();
        start_s = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input logic last, output bit ok);
        bit acc;
        byte_s  = b;
        last_s  = last;
        valid_s = 1'b1;
        ok      = 1'b0;
        for (int n = 0; n < 20; n++) begin
            acc = ready_m;
            tick();
            if (acc) begin
                ok = 1'b1;
                break;
            end
        end
        valid_s = 1'b0;
        last_s  = 1'b0;
    endtask

    function automatic vec_t mk(int n, bit gap, logic [63:0] b, int nwr,
                                logic [31:0] d0, logic [3:0] w0,
                                logic [31:0] d1, logic [3:0] w1);
        vec_t v;
        v.n     = n[3:0];
        v.gap   = gap;
        v.bytes = b;
        v.nwr   = nwr[1:0];
        v.data  = {d1, d0};
        v.wr    = {w1, w0};
        return v;
    endfunction

    task automatic chk_writes(input string nm, input int nwr,
                              input logic [1:0][31:0] d,
                              input logic [1:0][3:0] w);
        chk({nm, "_nwrites"}, wq.size(), nwr);
        for (int k = 0; k < nwr; k++) begin
            if (wq.size() > k) begin
                chk({nm, "_addr"}, {18'd0, wq[k].addr}, k);
                chk({nm, "_data"}, wq[k].data, d[k]);
                chk({nm, "_wr"}, {28'd0, wq[k].wr}, {28'd0, w[k]});
            end
        end
    endtask

    initial begin
        bit ok;
        vec_t v;
        reset   = 1'b1;
        start_s = 1'b0;
        sel     = 1'b0;
        byte_s  = 8'h00;
        valid_s = 1'b0;
        last_s  = 1'b0;

        vecs[0] = mk(4, 0, 64'h00000013, 1, 32'h00000013, 4'hF, 32'h0, 4'h0);
        vecs[1] = mk(6, 0, 64'h161514131211, 2,
                     32'h14131211, 4'hF, 32'h00001615, 4'h3);
        vecs[2] = mk(8, 1, 64'h2827262524232221, 2,
                     32'h24232221, 4'hF, 32'h28272625, 4'hF);
        vecs[3] = mk(8, 0, 64'h2827262524232221, 2,
                     32'h24232221, 4'hF, 32'h28272625, 4'hF);
        vecs[4] = mk(3, 0, 64'hC0B0A0, 1, 32'h00C0B0A0, 4'h7, 32'h0, 4'h0);
        vecs[5] = mk(1, 1, 64'h5A, 1, 32'h0000005A, 4'h1, 32'h0, 4'h0);

        #12;
        chk("rst_wr", {28'd0, wr_m}, 0);
        chk("rst_ready", {31'd0, ready_m}, 0);
        chk("rst_addr", {18'd0, addr_m}, 0);
        chk("rst_data", data_m, 0);
        chk("rst_cpu_reset", {31'd0, crst_m}, 1);
        chk("rst_done", {31'd0, done_m}, 0);
        chk("rst_error", {31'd0, err_m}, 0);
        chk("rst_ww", {17'd0, ww_m}, 0);
        @(negedge clock);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            v = vecs[i];
            wq.delete();
            rdy_bad = 0;
            pulse_start();
            chk("start_cpu_reset", {31'd0, crst_m}, 1);
            chk("start_done", {31'd0, done_m}, 0);
            chk("start_ww", {17'd0, ww_m}, 0);
            for (int j = 0; j < int'(v.n); j++) begin
                send(v.bytes[8*j +: 8], j == int'(v.n) - 1, ok);
                chk("byte_accept", {31'd0, ok}, 1);
                if (v.gap && j < int'(v.n) - 1) tick();
            end
            tick();
            chk_writes("vec", int'(v.nwr), v.data, v.wr);
            chk("vec_done", {31'd0, done_m}, 1);
            chk("vec_cpu_reset", {31'd0, crst_m}, 0);
            chk("vec_error", {31'd0, err_m}, 0);
            chk("vec_ww", {17'd0, ww_m}, {30'd0, v.nwr});
            chk("vec_ready_idle", {31'd0, ready_m}, 0);
            chk("vec_wr_idle", {28'd0, wr_m}, 0);
            chk("vec_ready_in_write", rdy_bad, 0);
        end

        sel = 1'b1;
        wq.delete();
        pulse_start();
        for (int j = 0; j < 8; j++) begin
            send(8'h31 + 8'(j), 1'b0, ok);
            chk("ovf_accept", {31'd0, ok}, 1);
        end
        send(8'h39, 1'b0, ok);
        chk("ovf_9th_rejected", {31'd0, ok}, 0);
        chk_writes("ovf", 2, {32'h38373635, 32'h34333231}, {4'hF, 4'hF});
        chk("ovf_error", {31'd0, err_m}, 1);
        chk("ovf_cpu_reset", {31'd0, crst_m}, 1);
        chk("ovf_done", {31'd0, done_m}, 0);
        chk("ovf_ww", {17'd0, ww_m}, 2);
        chk("ovf_wr_idle", {28'd0, wr_m}, 0);

        sel = 1'b0;
        wq.delete();
        pulse_start();
        send(8'h77, 1'b0, ok);
        send(8'h88, 1'b0, ok);
        reset = 1'b1;
        #2;
        chk("midrst_wr", {28'd0, wr_m}, 0);
        chk("midrst_cpu_reset", {31'd0, crst_m}, 1);
        chk("midrst_ready", {31'd0, ready_m}, 0);
        chk("midrst_data", data_m, 0);
        chk("midrst_done", {31'd0, done_m}, 0);
        @(negedge clock);
        reset = 1'b0;
        tick();
        tick();
        chk("midrst_no_write", wq.size(), 0);
        pulse_start();
        send(8'hAA, 1'b0, ok);
        send(8'hBB, 1'b0, ok);
        send(8'hCC, 1'b0, ok);
        send(8'hDD, 1'b1, ok);
        tick();
        chk_writes("midrst", 1, {32'h0, 32'hDDCCBBAA}, {4'h0, 4'hF});
        chk("midrst_done_after", {31'd0, done_m}, 1);
        chk("midrst_ww", {17'd0, ww_m}, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
